// File: rtl/prf_free_list_pkg.sv
// Shared constants and types for the physical register free list.
// LG_PRF/N_PRF fix the default PRF geometry used by rename.
package prf_free_list_pkg;
  localparam int LG_PRF         = 6;
  localparam int N_PRF          = 1 << LG_PRF;
  localparam int N_RESERVED_DEF = 32;

  typedef logic [LG_PRF-1:0] prf_id_t;
  typedef logic [N_PRF-1:0]  prf_mask_t;
endpackage

// File: rtl/prf_free_list_ffs.sv
// Lowest-index set-bit finder over 1<<LG_N inputs.
// y[LG_N] is set when no input bit is set; y[LG_N-1:0] is then zero.
module find_first_set #(
  parameter int LG_N = 6
) (
  input  logic [(1<<LG_N)-1:0] a,
  output logic [LG_N:0]        y
);
  localparam int N = 1 << LG_N;

  always_comb begin
    y = {1'b1, {LG_N{1'b0}}};
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i]) y = {1'b0, LG_N'(i)};
    end
  end
endmodule

// File: rtl/prf_free_list.sv
// Free-list allocator for physical register IDs: bitmap of free entries with a
// registered lowest-index candidate, two retire free ports and a flush rollback mask.
module prf_free_list
  import prf_free_list_pkg::*;
#(
  parameter int LG_N       = LG_PRF,
  parameter int N_RESERVED = N_RESERVED_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alloc_req,
  output logic                   alloc_valid,
  output logic [LG_N-1:0]        alloc_id,
  input  logic                   free0_valid,
  input  logic [LG_N-1:0]        free0_id,
  input  logic                   free1_valid,
  input  logic [LG_N-1:0]        free1_id,
  input  logic                   rollback_valid,
  input  logic [(1<<LG_N)-1:0]   rollback_mask,
  output logic [LG_N:0]          free_count,
  output logic                   double_free_err
);
  localparam int N = 1 << LG_N;

  localparam logic [LG_N-1:0] RST_ID  = (N_RESERVED < N) ? LG_N'(N_RESERVED) : '0;
  localparam logic [LG_N:0]   RST_CNT = (LG_N+1)'(N - N_RESERVED);

  function automatic logic [N-1:0] reset_map();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i >= N_RESERVED);
    return m;
  endfunction

  function automatic logic [LG_N:0] popcount(input logic [N-1:0] m);
    logic [LG_N:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + (LG_N+1)'(m[i]);
    return c;
  endfunction

  logic [N-1:0]    bitmap_q, bitmap_d;
  logic            next_valid_q, next_valid_d;
  logic [LG_N-1:0] next_id_q, next_id_d;
  logic [LG_N:0]   count_q, count_d;
  logic            err_q, err_d;

  logic            grant;
  logic [N-1:0]    grant_oh, f0_oh, f1_oh, rb_mask;
  logic [LG_N:0]   ffs_y;

  assign grant    = alloc_req & next_valid_q;
  assign grant_oh = {{(N-1){1'b0}}, grant} << alloc_id;
  assign f0_oh    = {{(N-1){1'b0}}, free0_valid} << free0_id;
  assign f1_oh    = {{(N-1){1'b0}}, free1_valid} << free1_id;
  assign rb_mask  = rollback_valid ? rollback_mask : '0;

  // Frees and rollback are OR'd after the grant clear so they win on overlap.
  assign bitmap_d = (bitmap_q & ~grant_oh) | f0_oh | f1_oh | rb_mask;

  // Any free of an entry already marked free (including the offered one) is an
  // error; a same-cycle duplicate on both ports is an error even if allocated.
  assign err_d = (free0_valid & bitmap_q[free0_id])
               | (free1_valid & bitmap_q[free1_id])
               | (free0_valid & free1_valid & (free0_id == free1_id));

  find_first_set #(.LG_N(LG_N)) u_ffs (
    .a (bitmap_d),
    .y (ffs_y)
  );

  assign next_valid_d = ~ffs_y[LG_N];
  assign next_id_d    = ffs_y[LG_N-1:0];
  assign count_d      = popcount(bitmap_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bitmap_q     <= reset_map();
      next_valid_q <= (N_RESERVED < N);
      next_id_q    <= RST_ID;
      count_q      <= RST_CNT;
      err_q        <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      next_valid_q <= next_valid_d;
      next_id_q    <= next_id_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign alloc_valid     = next_valid_q;
  assign alloc_id        = next_id_q;
  assign free_count      = count_q;
  assign double_free_err = err_q;
endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list: stimulus pushes expected next-cycle outputs,
// a monitor pops them after each clock edge and compares.
module tb_prf_free_list;
  localparam int LG_N = 6;
  localparam int N    = 1 << LG_N;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alloc_req;
  logic            alloc_valid;
  logic [LG_N-1:0] alloc_id;
  logic            free0_valid;
  logic [LG_N-1:0] free0_id;
  logic            free1_valid;
  logic [LG_N-1:0] free1_id;
  logic            rollback_valid;
  logic [N-1:0]    rollback_mask;
  logic [LG_N:0]   free_count;
  logic            double_free_err;

  prf_free_list #(.LG_N(LG_N), .N_RESERVED(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_id        (alloc_id),
    .free0_valid     (free0_valid),
    .free0_id        (free0_id),
    .free1_valid     (free1_valid),
    .free1_id        (free1_id),
    .rollback_valid  (rollback_valid),
    .rollback_mask   (rollback_mask),
    .free_count      (free_count),
    .double_free_err (double_free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    v;
    bit    chk_id;
    int    id;
    int    cnt;
    bit    err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (alloc_valid !== e.v) begin
        errors++;
        $display("FAIL %s alloc_valid: got %0b want %0b", e.name, alloc_valid, e.v);
      end
      if (e.chk_id) begin
        checks++;
        if (alloc_id !== LG_N'(e.id)) begin
          errors++;
          $display("FAIL %s alloc_id: got %0d want %0d", e.name, alloc_id, e.id);
        end
      end
      checks++;
      if (free_count !== (LG_N+1)'(e.cnt)) begin
        errors++;
        $display("FAIL %s free_count: got %0d want %0d", e.name, free_count, e.cnt);
      end
      checks++;
      if (double_free_err !== e.err) begin
        errors++;
        $display("FAIL %s double_free_err: got %0b want %0b", e.name, double_free_err, e.err);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input string name, input bit rn, input bit ar,
                      input bit f0v, input int f0, input bit f1v, input int f1,
                      input bit rbv, input logic [N-1:0] rbm,
                      input bit ev, input bit ecid, input int eid, input int ecnt,
                      input bit eerr);
    exp_t e;
    @(negedge clk);
    reset_n        = rn;
    alloc_req      = ar;
    free0_valid    = f0v;
    free0_id       = LG_N'(f0);
    free1_valid    = f1v;
    free1_id       = LG_N'(f1);
    rollback_valid = rbv;
    rollback_mask  = rbm;
    e.name = name; e.v = ev; e.chk_id = ecid; e.id = eid; e.cnt = ecnt; e.err = eerr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string name, input bit ev, input bit ecid, input int eid,
                      input int ecnt, input bit eerr);
    step(name, 1, 0, 0, 0, 0, 0, 0, '0, ev, ecid, eid, ecnt, eerr);
  endtask

  initial begin
    logic [N-1:0] m;
    reset_n = 1'b0; alloc_req = 1'b0; free0_valid = 1'b0; free0_id = '0;
    free1_valid = 1'b0; free1_id = '0; rollback_valid = 1'b0; rollback_mask = '0;

    step("reset", 0, 0, 0, 0, 0, 0, 0, '0, 1, 1, 32, 32, 0);
    step("reset2", 0, 0, 0, 0, 0, 0, 0, '0, 1, 1, 32, 32, 0);
    idle("post_reset", 1, 1, 32, 32, 0);

    // Drain: offered id 32+k is granted, next offer is 33+k.
    for (int k = 0; k < 31; k++)
      step("drain", 1, 1, 0, 0, 0, 0, 0, '0, 1, 1, 33 + k, 31 - k, 0);
    step("drain_last", 1, 1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    step("empty_req", 1, 1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);

    step("free_40_35", 1, 0, 1, 40, 1, 35, 0, '0, 1, 1, 35, 2, 0);
    step("grant_35", 1, 1, 0, 0, 0, 0, 0, '0, 1, 1, 40, 1, 0);
    step("grant_40", 1, 1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);

    step("free_33", 1, 0, 1, 33, 0, 0, 0, '0, 1, 1, 33, 1, 0);
    m = '0; m[10] = 1'b1; m[50] = 1'b1;
    step("grant_rollback", 1, 1, 0, 0, 0, 0, 1, m, 1, 1, 10, 2, 0);
    step("grant_10", 1, 1, 0, 0, 0, 0, 0, '0, 1, 1, 50, 1, 0);
    step("grant_50", 1, 1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);

    step("free_45", 1, 0, 1, 45, 0, 0, 0, '0, 1, 1, 45, 1, 0);
    step("dfree_45", 1, 0, 1, 45, 0, 0, 0, '0, 1, 1, 45, 1, 1);
    idle("dfree_45_clear", 1, 1, 45, 1, 0);
    step("dfree_20_dup", 1, 0, 1, 20, 1, 20, 0, '0, 1, 1, 20, 2, 1);
    idle("dfree_20_clear", 1, 1, 20, 2, 0);
    step("free_granted", 1, 1, 1, 20, 0, 0, 0, '0, 1, 1, 20, 2, 1);
    step("dfree_port1", 1, 0, 0, 0, 1, 45, 0, '0, 1, 1, 20, 2, 1);

    m = '1;
    step("rollback_all", 1, 0, 0, 0, 0, 0, 1, m, 1, 1, 0, 64, 0);
    step("full_free", 1, 0, 1, 5, 0, 0, 0, '0, 1, 1, 0, 64, 1);
    step("grant_0", 1, 1, 0, 0, 0, 0, 0, '0, 1, 1, 1, 63, 0);

    m = '0; m[3] = 1'b1;
    step("mid_reset", 0, 1, 1, 3, 1, 7, 1, m, 1, 1, 32, 32, 0);
    idle("after_reset", 1, 1, 32, 32, 0);
    step("after_reset_grant", 1, 1, 0, 0, 0, 0, 0, '0, 1, 1, 33, 31, 0);

    @(negedge clk);
    alloc_req = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
